// File: rtl/request_ager.sv
// rtl/request_ager.sv - two-channel request ager feeding a downstream priority arbiter
// Each channel waits with an aging priority, holds while granted, and resumes waiting on preemption.
module request_ager_chan #(
   parameter int AGE_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req,
   input  logic [1:0] base_p,
   input  logic [3:0] len,
   input  logic       g,
   output logic       r,
   output logic [1:0] p,
   output logic       done,
   output logic       drop
);
   localparam logic [3:0] AGE_MAX = 4'(AGE_TICKS - 1);

   typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

   state_t     state, state_n;
   logic [3:0] age, age_n;
   logic [3:0] rem, rem_n;
   logic [1:0] pri, pri_n;
   logic       done_q, done_n;
   logic       drop_q, drop_n;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         age    <= 4'd0;
         rem    <= 4'd0;
         pri    <= 2'd0;
         done_q <= 1'b0;
         drop_q <= 1'b0;
      end else begin
         state  <= state_n;
         age    <= age_n;
         rem    <= rem_n;
         pri    <= pri_n;
         done_q <= done_n;
         drop_q <= drop_n;
      end
   end

   always_comb begin
      state_n = state;
      age_n   = age;
      rem_n   = rem;
      pri_n   = pri;
      done_n  = 1'b0;
      drop_n  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               state_n = WAIT;
               pri_n   = base_p;
               rem_n   = (len == 4'd0) ? 4'd1 : len;
               age_n   = 4'd0;
            end
         end
         WAIT: begin
            drop_n = req;
            // A grant freezes aging on the same edge it moves the channel to HOLD.
            if (g) begin
               state_n = HOLD;
            end else if (age == AGE_MAX) begin
               age_n = 4'd0;
               if (pri != 2'd3)
                  pri_n = pri + 2'd1;
            end else begin
               age_n = age + 4'd1;
            end
         end
         HOLD: begin
            drop_n = req;
            if (g) begin
               if (rem == 4'd1) begin
                  state_n = IDLE;
                  pri_n   = 2'd0;
                  rem_n   = 4'd0;
                  done_n  = 1'b1;
               end else begin
                  rem_n = rem - 4'd1;
               end
            end else begin
               state_n = WAIT;
               age_n   = 4'd0;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign r    = (state != IDLE);
   assign p    = pri;
   assign done = done_q;
   assign drop = drop_q;
endmodule

module request_ager #(
   parameter int AGE_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_a,
   input  logic       req_b,
   input  logic [1:0] base_pa,
   input  logic [1:0] base_pb,
   input  logic [3:0] len_a,
   input  logic [3:0] len_b,
   input  logic       ga,
   input  logic       gb,
   output logic       ra,
   output logic       rb,
   output logic [1:0] PA,
   output logic [1:0] PB,
   output logic       done_a,
   output logic       done_b,
   output logic       drop_a,
   output logic       drop_b
);
   request_ager_chan #(.AGE_TICKS(AGE_TICKS)) u_chan_a (
      .clk(clk), .rst(rst), .req(req_a), .base_p(base_pa), .len(len_a), .g(ga),
      .r(ra), .p(PA), .done(done_a), .drop(drop_a)
   );

   request_ager_chan #(.AGE_TICKS(AGE_TICKS)) u_chan_b (
      .clk(clk), .rst(rst), .req(req_b), .base_p(base_pb), .len(len_b), .g(gb),
      .r(rb), .p(PB), .done(done_b), .drop(drop_b)
   );
endmodule

// File: tb/tb_request_ager.sv
// tb/tb_request_ager.sv - directed vector bench for request_ager
module tb_request_ager;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       req_a = 1'b0, req_b = 1'b0;
   logic [1:0] base_pa = 2'd0, base_pb = 2'd0;
   logic [3:0] len_a = 4'd0, len_b = 4'd0;
   logic       ga = 1'b0, gb = 1'b0;
   logic       ra, rb, done_a, done_b, drop_a, drop_b;
   logic [1:0] PA, PB;

   int total = 0;
   int passed = 0;

   request_ager #(.AGE_TICKS(4)) dut (
      .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b),
      .base_pa(base_pa), .base_pb(base_pb), .len_a(len_a), .len_b(len_b),
      .ga(ga), .gb(gb), .ra(ra), .rb(rb), .PA(PA), .PB(PB),
      .done_a(done_a), .done_b(done_b), .drop_a(drop_a), .drop_b(drop_b)
   );

   always #5 clk = ~clk;

   wire [9:0] obs = {ra, PA, done_a, drop_a, rb, PB, done_b, drop_b};

   typedef struct {
      logic       rst;
      logic       req_a;
      logic [1:0] bpa;
      logic [3:0] la;
      logic       ga;
      logic       req_b;
      logic [1:0] bpb;
      logic [3:0] lb;
      logic       gb;
      logic [9:0] exp;
   } vec_t;

   vec_t vt[20];

   function automatic logic [9:0] ex(logic a, logic [1:0] pa, logic da, logic dra,
                                     logic b, logic [1:0] pb, logic db, logic drb);
      return {a, pa, da, dra, b, pb, db, drb};
   endfunction

   function automatic vec_t mk(logic r, logic qa, logic [1:0] pa, logic [3:0] la, logic g_a,
                               logic qb, logic [1:0] pb, logic [3:0] lb, logic g_b, logic [9:0] e);
      vec_t v;
      v.rst = r; v.req_a = qa; v.bpa = pa; v.la = la; v.ga = g_a;
      v.req_b = qb; v.bpb = pb; v.lb = lb; v.gb = g_b; v.exp = e;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] want);
      total++;
      if (act === want) passed++;
      else $display("FAIL %s: got %b expected %b", name, act, want);
   endtask

   task automatic idle_in();
      rst = 1'b1; req_a = 1'b0; req_b = 1'b0; ga = 1'b0; gb = 1'b0;
      base_pa = 2'd0; base_pb = 2'd0; len_a = 4'd0; len_b = 4'd0;
   endtask

   logic [9:0] z;
   logic [1:0] pexp;
   logic       gpat [1:11];
   int         dones;

   initial begin
      z = 10'd0;
      vt[0]  = mk(0, 1, 2'd0, 4'd0, 1, 1, 2'd0, 4'd0, 1, z);
      vt[1]  = mk(0, 1, 2'd0, 4'd0, 1, 1, 2'd0, 4'd0, 1, z);
      vt[2]  = mk(1, 0, 2'd0, 4'd0, 0, 0, 2'd0, 4'd0, 0, z);
      vt[3]  = mk(1, 0, 2'd0, 4'd0, 1, 0, 2'd0, 4'd0, 1, z);
      vt[4]  = mk(1, 1, 2'd1, 4'd3, 0, 0, 2'd0, 4'd0, 0, ex(1, 2'd1, 0, 0, 0, 2'd0, 0, 0));
      vt[5]  = mk(1, 0, 2'd0, 4'd0, 0, 0, 2'd0, 4'd0, 0, ex(1, 2'd1, 0, 0, 0, 2'd0, 0, 0));
      vt[6]  = mk(1, 0, 2'd0, 4'd0, 1, 0, 2'd0, 4'd0, 0, ex(1, 2'd1, 0, 0, 0, 2'd0, 0, 0));
      vt[7]  = mk(1, 0, 2'd0, 4'd0, 1, 0, 2'd0, 4'd0, 0, ex(1, 2'd1, 0, 0, 0, 2'd0, 0, 0));
      vt[8]  = mk(1, 1, 2'd3, 4'd9, 1, 0, 2'd0, 4'd0, 0, ex(1, 2'd1, 0, 1, 0, 2'd0, 0, 0));
      vt[9]  = mk(1, 0, 2'd0, 4'd0, 1, 0, 2'd0, 4'd0, 0, ex(0, 2'd0, 1, 0, 0, 2'd0, 0, 0));
      vt[10] = mk(1, 0, 2'd0, 4'd0, 0, 0, 2'd0, 4'd0, 0, z);
      vt[11] = mk(1, 0, 2'd0, 4'd0, 0, 1, 2'd2, 4'd0, 0, ex(0, 2'd0, 0, 0, 1, 2'd2, 0, 0));
      vt[12] = mk(1, 0, 2'd0, 4'd0, 0, 0, 2'd0, 4'd0, 1, ex(0, 2'd0, 0, 0, 1, 2'd2, 0, 0));
      vt[13] = mk(1, 0, 2'd0, 4'd0, 0, 1, 2'd1, 4'd7, 1, ex(0, 2'd0, 0, 0, 0, 2'd0, 1, 1));
      vt[14] = mk(1, 0, 2'd0, 4'd0, 0, 0, 2'd0, 4'd0, 0, z);
      vt[15] = mk(1, 1, 2'd3, 4'd1, 0, 1, 2'd0, 4'd2, 0, ex(1, 2'd3, 0, 0, 1, 2'd0, 0, 0));
      vt[16] = mk(1, 0, 2'd0, 4'd0, 1, 0, 2'd0, 4'd0, 1, ex(1, 2'd3, 0, 0, 1, 2'd0, 0, 0));
      vt[17] = mk(1, 0, 2'd0, 4'd0, 1, 0, 2'd0, 4'd0, 1, ex(0, 2'd0, 1, 0, 1, 2'd0, 0, 0));
      vt[18] = mk(1, 0, 2'd0, 4'd0, 1, 0, 2'd0, 4'd0, 1, ex(0, 2'd0, 0, 0, 0, 2'd0, 1, 0));
      vt[19] = mk(1, 0, 2'd0, 4'd0, 0, 0, 2'd0, 4'd0, 0, z);

      #1;
      for (int i = 0; i < 20; i++) begin
         rst = vt[i].rst; req_a = vt[i].req_a; base_pa = vt[i].bpa; len_a = vt[i].la; ga = vt[i].ga;
         req_b = vt[i].req_b; base_pb = vt[i].bpb; len_b = vt[i].lb; gb = vt[i].gb;
         tick();
         chk($sformatf("vec%0d", i), obs, vt[i].exp);
      end

      // Aging on B with no grant: priority climbs every 4 cycles and saturates at 3.
      idle_in();
      req_b = 1'b1; base_pb = 2'd0; len_b = 4'd5;
      tick();
      chk("age_k0", obs, ex(0, 2'd0, 0, 0, 1, 2'd0, 0, 0));
      idle_in();
      for (int k = 1; k <= 17; k++) begin
         tick();
         pexp = (k >= 12) ? 2'd3 : 2'(k / 4);
         chk($sformatf("age_k%0d", k), obs, ex(0, 2'd0, 0, 0, 1, pexp, 0, 0));
      end
      rst = 1'b0;
      tick();
      chk("reset_in_wait", obs, z);
      idle_in();

      // Preemption on A: len 5, granted 2, preempted 3, then granted to completion.
      gpat[1] = 1; gpat[2] = 1; gpat[3] = 0; gpat[4] = 0; gpat[5] = 0;
      gpat[6] = 1; gpat[7] = 1; gpat[8] = 1; gpat[9] = 1; gpat[10] = 1; gpat[11] = 0;
      req_a = 1'b1; base_pa = 2'd2; len_a = 4'd5;
      tick();
      chk("pre_start", obs, ex(1, 2'd2, 0, 0, 0, 2'd0, 0, 0));
      idle_in();
      dones = 0;
      for (int e = 1; e <= 11; e++) begin
         ga = gpat[e];
         tick();
         if (done_a) dones++;
         chk($sformatf("pre_e%0d", e), obs,
             ex(e < 10, (e < 10) ? 2'd2 : 2'd0, e == 10, 0, 0, 2'd0, 0, 0));
      end
      chk("pre_done_count", 10'(dones), 10'd1);
      idle_in();

      // Reset in the middle of HOLD aborts without a done pulse.
      req_a = 1'b1; base_pa = 2'd1; len_a = 4'd4;
      tick();
      chk("mid_start", obs, ex(1, 2'd1, 0, 0, 0, 2'd0, 0, 0));
      req_a = 1'b0; ga = 1'b1;
      tick();
      tick();
      chk("mid_hold", obs, ex(1, 2'd1, 0, 0, 0, 2'd0, 0, 0));
      rst = 1'b0; req_a = 1'b1;
      tick();
      chk("mid_reset", obs, z);
      rst = 1'b1; req_a = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("mid_after%0d", k), obs, z);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
